// File: rtl/latch_cond_pkg.sv
// Shared types and default constants for the NOR-latch input conditioner.
// The debounce cells and the top level import this package.
package latch_cond_pkg;

  typedef enum logic [1:0] {
    DB_LOW,
    DB_WAIT_HI,
    DB_HIGH,
    DB_WAIT_LO
  } db_state_t;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 50000;
  localparam int unsigned DEF_CNT_WIDTH     = 16;

endpackage : latch_cond_pkg

// File: rtl/debounce_cell.sv
// One raw board input -> synchroniser chain -> counter-based debounce FSM -> clean level.
// A new level is accepted after STABLE_CYCLES consecutive identical synced samples.
module debounce_cell
  import latch_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  // The sample that moves the FSM into a WAIT state is the first stable sample,
  // so the WAIT state must see STABLE_CYCLES-1 more, ending at count STABLE_CYCLES-2.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_x;
  db_state_t              state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s_x = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DB_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      unique case (state_q)
        DB_LOW: begin
          if (s_x) begin
            state_q <= DB_WAIT_HI;
            cnt_q   <= '0;
          end
        end
        DB_WAIT_HI: begin
          if (!s_x) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            // Counter holds at the compare point; it is cleared on the next WAIT entry.
            state_q <= DB_HIGH;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        DB_HIGH: begin
          if (!s_x) begin
            state_q <= DB_WAIT_LO;
            cnt_q   <= '0;
          end
        end
        DB_WAIT_LO: begin
          if (s_x) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_LOW;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= DB_LOW;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_q;

endmodule : debounce_cell

// File: rtl/latch_input_conditioner.sv
// Conditions the enable button and data switch feeding the NOR-gate D latch:
// debounced En/D levels, one-cycle enable edge strobes, and a D hold guard on En fall.
module latch_input_conditioner
  import latch_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en_raw,
  input  logic d_raw,
  output logic en_out,
  output logic d_out,
  output logic en_rise,
  output logic en_fall
);

  logic en_level;
  logic d_level;
  logic en_prev_q, en_prev_d;
  logic dout_prev_q, dout_prev_d;
  logic hold;

  debounce_cell #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_en_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (en_raw),
    .level(en_level)
  );

  debounce_cell #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_d_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (d_raw),
    .level(d_level)
  );

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    en_out  = en_level;
    en_rise = en_level & ~en_prev_q;
    en_fall = ~en_level & en_prev_q;
    // D must not move in the cycle En closes the latch; it follows one cycle later.
    hold    = en_fall & (d_level != dout_prev_q);
    d_out   = hold ? dout_prev_q : d_level;
    en_prev_d   = en_level;
    dout_prev_d = d_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_prev_q   <= 1'b0;
      dout_prev_q <= 1'b0;
    end else begin
      en_prev_q   <= en_prev_d;
      dout_prev_q <= dout_prev_d;
    end
  end

endmodule : latch_input_conditioner

// File: tb/tb_latch_input_conditioner.sv
// Scoreboard bench: stimulus pushes expected output changes (cycle + value), a monitor
// pops one entry each time the DUT outputs change and compares cycle and value.
module tb_latch_input_conditioner;

  localparam int LAT = 6;  // SYNC_STAGES + STABLE_CYCLES

  logic clk = 1'b0;
  logic rst;
  logic en_raw;
  logic d_raw;
  logic en_out;
  logic d_out;
  logic en_rise;
  logic en_fall;

  latch_input_conditioner #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_WIDTH    (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en_raw (en_raw),
    .d_raw  (d_raw),
    .en_out (en_out),
    .d_out  (d_out),
    .en_rise(en_rise),
    .en_fall(en_fall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  val;  // {en_out, d_out, en_rise, en_fall}
  } ev_t;

  ev_t  exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic stim_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int dc, input logic [3:0] v);
    ev_t e;
    e.cyc = 32'(cyc + dc);
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: sample 1 ns after each rising edge, react to any output change.
  initial begin : monitor
    logic [3:0] prev_obs;
    logic [3:0] obs;
    ev_t        e;
    prev_obs = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      obs = {en_out, d_out, en_rise, en_fall};
      if (obs !== prev_obs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %b expected no change (cycle %0d)", obs, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_value", {28'd0, obs}, {28'd0, e.val});
        end
        prev_obs = obs;
      end
    end
  end

  initial begin : stimulus
    rst    = 1'b1;
    en_raw = 1'b1;
    d_raw  = 1'b1;
    ticks(3);
    check("reset_outputs", {28'd0, en_out, d_out, en_rise, en_fall}, 32'h0);

    // 1. release with both inputs already high: both levels appear after LAT edges
    rst = 1'b0;
    push(LAT,     4'b1110);
    push(LAT + 1, 4'b1100);
    ticks(10);

    // both fall together: hold guard keeps d_out high in the en_fall cycle
    en_raw = 1'b0;
    d_raw  = 1'b0;
    push(LAT,     4'b0101);
    push(LAT + 1, 4'b0000);
    ticks(10);

    // 2. bounce rejection on enable
    for (int i = 0; i < 8; i++) begin
      en_raw = (i % 2 == 0);
      ticks(1);
    end
    en_raw = 1'b0;
    ticks(12);

    // 3. short data glitch rejected, then 6-clk pulse accepted
    d_raw = 1'b1;
    ticks(3);
    d_raw = 1'b0;
    ticks(10);
    d_raw = 1'b1;
    push(LAT, 4'b0100);
    ticks(6);
    d_raw = 1'b0;
    push(LAT, 4'b0000);
    ticks(10);

    // 4. hold guard: en_out=1, d_out=0, then data rises as enable falls
    en_raw = 1'b1;
    push(LAT,     4'b1010);
    push(LAT + 1, 4'b1000);
    ticks(10);
    en_raw = 1'b0;
    d_raw  = 1'b1;
    push(LAT,     4'b0001);
    push(LAT + 1, 4'b0100);
    ticks(10);
    d_raw = 1'b0;
    push(LAT, 4'b0000);
    ticks(10);

    // 5. reset in the middle of WAIT_HI discards the count
    en_raw = 1'b1;
    ticks(3);
    rst = 1'b1;
    ticks(1);
    check("midreset_en_out", {31'd0, en_out}, 32'h0);
    rst = 1'b0;
    push(LAT,     4'b1010);
    push(LAT + 1, 4'b1000);
    ticks(10);

    // async reset with both outputs high clears them immediately
    d_raw = 1'b1;
    push(LAT, 4'b1100);
    ticks(10);
    rst = 1'b1;
    push(1, 4'b0000);
    #1;
    check("async_reset_outputs", {28'd0, en_out, d_out, en_rise, en_fall}, 32'h0);
    ticks(2);
    rst = 1'b0;
    push(LAT,     4'b1110);
    push(LAT + 1, 4'b1100);
    ticks(10);

    // 6. latch sequence D = 0/1/0 with En=1, then En=0 with D=1
    d_raw = 1'b0;
    push(LAT, 4'b1000);
    ticks(10);
    d_raw = 1'b1;
    push(LAT, 4'b1100);
    ticks(10);
    d_raw = 1'b0;
    push(LAT, 4'b1000);
    ticks(10);
    en_raw = 1'b0;
    d_raw  = 1'b1;
    push(LAT,     4'b0001);
    push(LAT + 1, 4'b0100);
    ticks(10);
    // data changes as enable rises: d_out updates without delay
    en_raw = 1'b1;
    d_raw  = 1'b0;
    push(LAT,     4'b1010);
    push(LAT + 1, 4'b1000);
    ticks(12);

    check("pending_events", 32'(exp_q.size()), 32'h0);
    stim_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin : watchdog
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: stimulus still running at cycle %0d, expected finish", cyc);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
    end
  end

endmodule : tb_latch_input_conditioner
